id_scoreboard: RTL and testbench
================================

// Module: id_scoreboard
// PURPOSE
//  Issue-stage register scoreboard with bypass selection. It replaces the stateless three-stage
//  stall comparator with per-register pending-write tracking.
//  Each destination register holds an age (producer's pipeline stage) and a data-ready latency.
//  ID consumers are either stalled or told which stage to forward from.
//  Sits between decode and the EXE issue register; driven by the pipeline advance/flush control.
// PARAMETERS
//  NREG      32  architectural registers tracked
//  AW        5   register index width, clog2(NREG)
//  NSRC      2   source operands checked per instruction
//  NSTG      3   stages after ID that hold a producer (1=EXE,2=MEM,3=WB); entry retires after NSTG
//  ZERO_REG  1   1: register 0 is never tracked and never hazards
//  CW        32  stall performance counter width
// PORTS
//  clk           in   1          clock, rising edge
//  rst           in   1          asynchronous reset, active-high
//  pipe_adv      in   1          pipeline advances this cycle (0 = downstream stall, ages hold)
//  flush         in   1          kill all in-flight producers (exception/branch recovery)
//  id_valid      in   1          ID holds a valid instruction
//  id_src_en     in   NSRC       per-source read enable
//  id_src        in   NSRC*AW    source indices, src i at [i*AW +: AW]
//  id_dst_en     in   1          instruction writes a register
//  id_dst        in   AW         destination index
//  id_lat        in   2          stage whose output first holds the result: 1=EXE,2=MEM,3=WB
//  id_ready      out  1          no unresolved source hazard
//  id_issue      out  1          id_valid & id_ready & pipe_adv & !flush
//  fwd_sel       out  NSRC*2     per source: 0=regfile, 1=EXE, 2=MEM, 3=WB bypass
//  stall_cnt     out  CW         cycles with id_valid & !id_ready, saturating
// BEHAVIOUR
//  - State per register r: vld[r], age[r] (2b, 1..NSTG), lat[r] (2b). Reset: all vld=0, stall_cnt=0.
//    Resulting outputs at reset: id_ready=1, fwd_sel=0, id_issue=id_valid&pipe_adv&!flush.
//  - Hazard, source i (en, idx s): vld[s] & age[s] < lat[s] -> stall. Combinational from state.
//    The combinational path must not pass through the same-cycle issue.
//    Not checked when en=0, or when s==0 and ZERO_REG=1.
//  - fwd_sel[i]: when vld[s] & age[s] >= lat[s], equals age[s]; otherwise 0. Also 0 while stalled.
//  - id_ready = no source stalls. id_ready is independent of pipe_adv and flush.
//  - Ageing: when pipe_adv=1, every vld entry does age+1.
//    An entry at age==NSTG clears vld instead (it is written back to the regfile this cycle).
//    When pipe_adv=0, all state holds.
//  - Issue (id_issue=1, id_dst_en=1, dst legal):
//    entry[dst] <= {vld=1, age=1, lat=id_lat}, overwriting any older producer (youngest wins).
//    Issue has priority over age/retire of the same entry in that cycle.
//  - id_lat=0 is illegal and is treated as 1. id_lat > NSTG is treated as NSTG.
//  - A source equal to its own instruction's dst checks the prior producer only.
//  - flush=1: all vld cleared next edge; no issue that cycle. flush dominates pipe_adv.
//  - stall_cnt: +1 per cycle with id_valid & !id_ready, holds at all-ones. Reset to 0 only by rst.
//  - Async rst mid-operation: all state clears immediately; outputs take reset values combinationally.
// STRUCTURE
//  - defines.vh: FWD_RF/FWD_EXE/FWD_MEM/FWD_WB codes, LAT_EXE/LAT_MEM/LAT_WB encodings.
//  - Sub-module sb_entry: vld/age/lat register with issue/advance/flush controls, instantiated NREG times.
//  - Source compare and mux logic stays in a generate loop in the top module.
// TESTING
//  1 Reset, id_valid=1 src=(5,6), no producers -> id_ready=1, fwd_sel=0/0, stall_cnt=0.
//  2 Issue ALU dst=5 lat=1, then a consumer of 5 next cycle
//    -> no stall, fwd_sel=1 (EXE); one cycle later fwd=2; then 3; then 0 after retire.
//  3 Issue load dst=7 lat=2, consumer of 7 next cycle
//    -> id_ready=0 for 1 cycle, stall_cnt=1, then fwd_sel=2 (MEM).
//  4 Two writers to r9 back-to-back (lat 1 then 2), consumer of r9
//    -> tracks the younger: stall once, then fwd=2, not the older's WB.
//  5 pipe_adv=0 for 3 cycles with load r7 at age 1 -> stall persists, age holds; releases after pipe_adv returns.
//  6 Producers r3, r4 in flight, flush=1 with id_valid -> no issue; next cycle all vld=0 and consumers ready.
//    Also: src=0 with ZERO_REG=1 and dst=0 issued -> never stalls.

Source files
------------

// File: rtl/id_scoreboard_pkg.sv
// Shared types and helpers for the issue-stage register scoreboard.
package id_scoreboard_pkg;

  // Bypass source codes driven on fwd_sel.
  typedef enum logic [1:0] {
    FwdRf  = 2'd0,
    FwdExe = 2'd1,
    FwdMem = 2'd2,
    FwdWb  = 2'd3
  } fwd_e;

  // Stage whose output first holds a producer's result.
  typedef enum logic [1:0] {
    LatIll = 2'd0,
    LatExe = 2'd1,
    LatMem = 2'd2,
    LatWb  = 2'd3
  } lat_e;

  // Per-register pending-write state.
  typedef struct packed {
    logic       vld;
    logic [1:0] age;
    logic [1:0] lat;
  } sb_entry_t;

  // A zero latency is meaningless and is read as EXE; anything past the last
  // producer stage is pinned to that stage.
  function automatic logic [1:0] clamp_lat(input logic [1:0] lat, input int unsigned nstg);
    if (lat == LatIll) return LatExe;
    if (32'(lat) > nstg) return 2'(nstg);
    return lat;
  endfunction

endpackage

// File: rtl/id_scoreboard_sb_entry.sv
// One scoreboard entry: tracks the youngest in-flight producer of a register.
module id_scoreboard_sb_entry
  import id_scoreboard_pkg::*;
#(
  parameter int unsigned NSTG = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush_i,
  input  logic       adv_i,
  input  logic       issue_i,
  input  logic [1:0] lat_i,
  output logic       vld_o,
  output logic [1:0] age_o,
  output logic [1:0] lat_o
);

  sb_entry_t ent_d, ent_q;

  // Next state: flush kills, a new issue overwrites, otherwise age or retire on advance.
  always_comb begin
    ent_d = ent_q;
    if (flush_i) begin
      ent_d.vld = 1'b0;
    end else if (issue_i) begin
      ent_d.vld = 1'b1;
      ent_d.age = 2'd1;
      ent_d.lat = lat_i;
    end else if (adv_i && ent_q.vld) begin
      if (ent_q.age == 2'(NSTG)) begin
        ent_d.vld = 1'b0;
      end else begin
        ent_d.age = ent_q.age + 2'd1;
      end
    end
  end

  // Entry state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_q <= '0;
    end else begin
      ent_q <= ent_d;
    end
  end

  assign vld_o = ent_q.vld;
  assign age_o = ent_q.age;
  assign lat_o = ent_q.lat;

endmodule

// File: rtl/id_scoreboard.sv
// Issue-stage scoreboard: per-register pending-write tracking with bypass selection.
module id_scoreboard
  import id_scoreboard_pkg::*;
#(
  parameter int unsigned NREG     = 32,
  parameter int unsigned AW       = 5,
  parameter int unsigned NSRC     = 2,
  parameter int unsigned NSTG     = 3,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned CW       = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pipe_adv,
  input  logic               flush,
  input  logic               id_valid,
  input  logic [NSRC-1:0]    id_src_en,
  input  logic [NSRC*AW-1:0] id_src,
  input  logic               id_dst_en,
  input  logic [AW-1:0]      id_dst,
  input  logic [1:0]         id_lat,
  output logic               id_ready,
  output logic               id_issue,
  output logic [NSRC*2-1:0]  fwd_sel,
  output logic [CW-1:0]      stall_cnt
);

  localparam bit SkipR0 = (ZERO_REG != 0);

  logic [NREG-1:0] ent_vld;
  logic [1:0]      ent_age [NREG];
  logic [1:0]      ent_lat [NREG];
  logic [1:0]      lat_eff;
  logic [NSRC-1:0] src_stall;
  logic [1:0]      src_fwd [NSRC];
  logic [CW-1:0]   stall_cnt_d, stall_cnt_q;

  assign lat_eff = clamp_lat(id_lat, NSTG);

  // id_ready depends only on registered state, so issue never loops back into it.
  assign id_ready = ~|src_stall;
  assign id_issue = id_valid & id_ready & pipe_adv & ~flush;

  for (genvar r = 0; r < NREG; r++) begin : g_ent
    logic issue_we;
    // Same-cycle issue to this register overrides its own ageing/retire.
    assign issue_we = id_issue && id_dst_en && (id_dst == AW'(r)) && !(SkipR0 && (r == 0));

    id_scoreboard_sb_entry #(
      .NSTG (NSTG)
    ) u_entry (
      .clk     (clk),
      .rst     (rst),
      .flush_i (flush),
      .adv_i   (pipe_adv),
      .issue_i (issue_we),
      .lat_i   (lat_eff),
      .vld_o   (ent_vld[r]),
      .age_o   (ent_age[r]),
      .lat_o   (ent_lat[r])
    );
  end

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    logic [AW-1:0] s;
    logic          pend;
    assign s = id_src[i*AW +: AW];
    // A matching producer is pending unless the read is disabled or targets r0.
    assign pend         = id_src_en[i] && !(SkipR0 && (s == '0)) && ent_vld[s];
    assign src_stall[i] = pend && (ent_age[s] < ent_lat[s]);
    assign src_fwd[i]   = (pend && !src_stall[i]) ? ent_age[s] : FwdRf;
    // Any stall blanks every bypass select.
    assign fwd_sel[i*2 +: 2] = id_ready ? src_fwd[i] : FwdRf;
  end

  // Saturating count of cycles ID holds a valid instruction it cannot issue.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (id_valid && !id_ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CW'(1);
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_id_scoreboard.sv
// Self-checking bench for id_scoreboard against a pipeline-slot reference model.
module tb_id_scoreboard;

  localparam int unsigned CW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_adv, flush, id_valid;
  logic [1:0]  id_src_en;
  logic [9:0]  id_src;
  logic        id_dst_en;
  logic [4:0]  id_dst;
  logic [1:0]  id_lat;
  logic        id_ready, id_issue;
  logic [3:0]  fwd_sel;
  logic [CW-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_scoreboard #(
    .NREG     (32),
    .AW       (5),
    .NSRC     (2),
    .NSTG     (3),
    .ZERO_REG (1),
    .CW       (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pipe_adv  (pipe_adv),
    .flush     (flush),
    .id_valid  (id_valid),
    .id_src_en (id_src_en),
    .id_src    (id_src),
    .id_dst_en (id_dst_en),
    .id_dst    (id_dst),
    .id_lat    (id_lat),
    .id_ready  (id_ready),
    .id_issue  (id_issue),
    .fwd_sel   (fwd_sel),
    .stall_cnt (stall_cnt)
  );

  // Reference model: the three downstream pipeline slots (1=EXE,2=MEM,3=WB),
  // each holding the instruction currently in that stage.
  logic        m_v [1:3];
  logic [4:0]  m_d [1:3];
  logic [1:0]  m_l [1:3];
  int unsigned m_cnt;

  function automatic int youngest(input logic [4:0] s);
    for (int k = 1; k <= 3; k++) if (m_v[k] && m_d[k] == s) return k;
    return 0;
  endfunction

  function automatic logic src_stall(input int i);
    logic [4:0] s;
    int k;
    s = id_src[i*5 +: 5];
    k = youngest(s);
    if (!id_src_en[i] || s == 5'd0 || k == 0) return 1'b0;
    return k < int'(m_l[k]);
  endfunction

  function automatic logic [1:0] src_fwd(input int i);
    logic [4:0] s;
    int k;
    s = id_src[i*5 +: 5];
    k = youngest(s);
    if (!id_src_en[i] || s == 5'd0 || k == 0) return 2'd0;
    return (k >= int'(m_l[k])) ? 2'(k) : 2'd0;
  endfunction

  function automatic logic m_ready();
    return !src_stall(0) && !src_stall(1);
  endfunction

  function automatic logic m_issue();
    return id_valid && m_ready() && pipe_adv && !flush;
  endfunction

  function automatic logic [3:0] m_fwd();
    return m_ready() ? {src_fwd(1), src_fwd(0)} : 4'h0;
  endfunction

  function automatic logic [9:0] pk(input logic r, input logic i, input logic [3:0] f,
                                    input int unsigned c);
    return {r, i, f, 4'(c)};
  endfunction

  function automatic logic [9:0] obs();
    return {id_ready, id_issue, fwd_sel, stall_cnt};
  endfunction

  task automatic model_clear();
    for (int k = 1; k <= 3; k++) m_v[k] = 1'b0;
    m_cnt = 0;
  endtask

  task automatic model_step();
    logic iss, rdy;
    iss = m_issue();
    rdy = m_ready();
    if (id_valid && !rdy && m_cnt != 15) m_cnt++;
    if (flush) begin
      for (int k = 1; k <= 3; k++) m_v[k] = 1'b0;
    end else if (pipe_adv) begin
      for (int k = 3; k >= 2; k--) begin
        m_v[k] = m_v[k-1]; m_d[k] = m_d[k-1]; m_l[k] = m_l[k-1];
      end
      m_v[1] = iss && id_dst_en && id_dst != 5'd0;
      m_d[1] = id_dst;
      m_l[1] = (id_lat == 2'd0) ? 2'd1 : id_lat;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] en, input logic [4:0] s0,
                       input logic [4:0] s1, input logic de, input logic [4:0] d,
                       input logic [1:0] lat, input logic adv, input logic fl);
    id_valid = v; id_src_en = en; id_src = {s1, s0};
    id_dst_en = de; id_dst = d; id_lat = lat; pipe_adv = adv; flush = fl;
  endtask

  // Called away from a clock edge; pulse stays clear of the next posedge.
  task automatic do_reset();
    drive(0, 2'b00, 0, 0, 0, 0, 2'd1, 1, 0);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    do_reset();
    drive(1, 2'b11, 5, 6, 0, 0, 2'd1, 1, 0);
    #2;
    checks++;
    if (obs() !== pk(1, 1, 4'h0, 0))
      $display("FAIL reset_state got %b want %b", obs(), pk(1, 1, 4'h0, 0));
    if (obs() !== pk(1, 1, 4'h0, 0)) errors++;
    tick();
  endtask

  task automatic test_alu_forward();
    logic [9:0] w;
    do_reset();
    drive(1, 2'b00, 0, 0, 1, 5, 2'd1, 1, 0);
    #2;
    checks++;
    if (obs() !== pk(1, 1, 4'h0, 0)) begin
      errors++; $display("FAIL alu_issue got %b want %b", obs(), pk(1, 1, 4'h0, 0));
    end
    tick();
    for (int c = 1; c <= 4; c++) begin
      drive(1, 2'b01, 5, 0, 0, 0, 2'd1, 1, 0);
      #2;
      w = pk(1, 1, (c == 4) ? 4'h0 : 4'(c), 0);
      checks++;
      if (obs() !== w) begin
        errors++; $display("FAIL alu_fwd c=%0d got %b want %b", c, obs(), w);
      end
      tick();
    end
  endtask

  task automatic test_load_stall();
    logic [9:0] w [3];
    w[0] = pk(1, 1, 4'h0, 0);
    w[1] = pk(0, 0, 4'h0, 0);
    w[2] = pk(1, 1, 4'b1000, 1);
    do_reset();
    for (int c = 0; c < 3; c++) begin
      if (c == 0) drive(1, 2'b00, 0, 0, 1, 7, 2'd2, 1, 0);
      else        drive(1, 2'b10, 0, 7, 0, 0, 2'd1, 1, 0);
      #2;
      checks++;
      if (obs() !== w[c]) begin
        errors++; $display("FAIL load_stall c=%0d got %b want %b", c, obs(), w[c]);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] w [5];
    w[0] = pk(1, 1, 4'h0, 0);
    w[1] = pk(1, 1, 4'b0001, 0);
    w[2] = pk(0, 0, 4'h0, 0);
    w[3] = pk(1, 1, 4'b0010, 1);
    w[4] = pk(1, 1, 4'b0011, 1);
    do_reset();
    for (int c = 0; c < 5; c++) begin
      if (c == 0)      drive(1, 2'b00, 0, 0, 1, 9, 2'd1, 1, 0);
      else if (c == 1) drive(1, 2'b01, 9, 0, 1, 9, 2'd2, 1, 0);
      else             drive(1, 2'b01, 9, 0, 0, 0, 2'd1, 1, 0);
      #2;
      checks++;
      if (obs() !== w[c]) begin
        errors++; $display("FAIL back_to_back c=%0d got %b want %b", c, obs(), w[c]);
      end
      tick();
    end
  endtask

  task automatic test_adv_hold_saturate();
    logic [9:0] w;
    do_reset();
    drive(1, 2'b00, 0, 0, 1, 7, 2'd2, 1, 0);
    tick();
    for (int n = 0; n < 20; n++) begin
      drive(1, 2'b01, 7, 0, 0, 0, 2'd1, 0, 0);
      #2;
      w = pk(0, 0, 4'h0, (n > 15) ? 15 : n);
      checks++;
      if (obs() !== w) begin
        errors++; $display("FAIL adv_hold n=%0d got %b want %b", n, obs(), w);
      end
      tick();
    end
    for (int c = 0; c < 2; c++) begin
      drive(1, 2'b01, 7, 0, 0, 0, 2'd1, 1, 0);
      #2;
      w = (c == 0) ? pk(0, 0, 4'h0, 15) : pk(1, 1, 4'b0010, 15);
      checks++;
      if (obs() !== w) begin
        errors++; $display("FAIL adv_release c=%0d got %b want %b", c, obs(), w);
      end
      tick();
    end
  endtask

  task automatic test_flush();
    logic [9:0] w [5];
    w[0] = pk(1, 1, 4'h0, 0);
    w[1] = pk(1, 1, 4'h0, 0);
    w[2] = pk(1, 0, 4'b0010, 0);
    w[3] = pk(1, 1, 4'h0, 0);
    w[4] = pk(1, 1, 4'h0, 0);
    do_reset();
    for (int c = 0; c < 5; c++) begin
      case (c)
        0:       drive(1, 2'b00, 0, 0, 1, 3, 2'd1, 1, 0);
        1:       drive(1, 2'b00, 0, 0, 1, 4, 2'd2, 1, 0);
        2:       drive(1, 2'b01, 3, 0, 1, 10, 2'd1, 1, 1);
        3:       drive(1, 2'b11, 3, 4, 0, 0, 2'd1, 1, 0);
        default: drive(1, 2'b11, 10, 10, 0, 0, 2'd1, 1, 0);
      endcase
      #2;
      checks++;
      if (obs() !== w[c]) begin
        errors++; $display("FAIL flush c=%0d got %b want %b", c, obs(), w[c]);
      end
      tick();
    end
  endtask

  task automatic test_zero_reg();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      drive(1, (c == 0) ? 2'b01 : 2'b11, 0, 0, 1, 0, 2'd3, 1, 0);
      #2;
      checks++;
      if (obs() !== pk(1, 1, 4'h0, 0)) begin
        errors++; $display("FAIL zero_reg c=%0d got %b want %b", c, obs(), pk(1, 1, 4'h0, 0));
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(1, 2'b00, 0, 0, 1, 7, 2'd3, 1, 0);
    tick();
    drive(1, 2'b01, 7, 0, 0, 0, 2'd1, 1, 0);
    #2;
    checks++;
    if (obs() !== pk(0, 0, 4'h0, 0)) begin
      errors++; $display("FAIL async_pre got %b want %b", obs(), pk(0, 0, 4'h0, 0));
    end
    tick();
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (obs() !== pk(1, 1, 4'h0, 0)) begin
      errors++; $display("FAIL async_during got %b want %b", obs(), pk(1, 1, 4'h0, 0));
    end
    rst = 1'b0;
    model_clear();
    #1;
    checks++;
    if (obs() !== pk(1, 1, 4'h0, 0)) begin
      errors++; $display("FAIL async_after got %b want %b", obs(), pk(1, 1, 4'h0, 0));
    end
    tick();
  endtask

  task automatic test_random();
    logic [9:0] w;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 99) < 85, 2'($urandom_range(0, 3)),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            $urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)),
            2'($urandom_range(0, 3)), $urandom_range(0, 9) < 8,
            $urandom_range(0, 19) == 0);
      #2;
      w = pk(m_ready(), m_issue(), m_fwd(), m_cnt);
      checks++;
      if (obs() !== w) begin
        errors++; $display("FAIL random n=%0d got %b want %b", n, obs(), w);
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_alu_forward();
    test_load_stall();
    test_back_to_back();
    test_adv_hold_saturate();
    test_flush();
    test_zero_reg();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
